pipo_rr_ctrl: RTL and testbench
===============================

Name: pipo_rr_ctrl

Overview:
Round-robin controller that shares one DW-bit pipo register between N_REQ requesters. It arbitrates requests and latches the winner's data. It drives the register's enb/i_data for exactly one load cycle, then holds ownership for HOLD_CYC cycles so the winner can read the register's o_data. It sits between the requester blocks and the pipo instance and is the only driver of that register's load inputs.

Parameters:
N_REQ, 4, number of requesters (2..16)
DW, 4, data width of the shared pipo register
HOLD_CYC, 2, cycles ownership is held after the load cycle (0..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
req  in  N_REQ  per-requester load request, level; held until ack
req_data  in  N_REQ*DW  requester data, slice i = bits [i*DW +: DW]
gnt  out  N_REQ  one-hot owner indication, high in LOAD and HOLD
ack  out  N_REQ  one-cycle pulse to owner, coincident with pipo_enb
pipo_enb  out  1  load strobe to pipo enb
pipo_data  out  DW  data to pipo i_data, registered
owner  out  $clog2(N_REQ)  index of current/last owner
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, ack=0, pipo_enb=0, pipo_data=0, owner=0, busy=0, hold counter=0, priority pointer=0 (index 0 highest).
- Reset mid-operation aborts the transaction. No ack is issued if reset hits before LOAD. The pipo register contents are not touched by this block.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - if req==0, stay in IDLE; all strobes low.
  - else pick the winner: the first set bit scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Next edge: state=LOAD, owner=winner, gnt=onehot(winner), pipo_data=req_data slice of winner (latched at this edge), ptr=(winner+1) mod N_REQ.
- LOAD (exactly 1 cycle): pipo_enb=1, ack[owner]=1, gnt held. The pipo captures pipo_data at the end of this cycle.
  - Next: HOLD if HOLD_CYC>0, else IDLE.
- HOLD: pipo_enb=0, ack=0, gnt held, counter counts 1..HOLD_CYC. After HOLD_CYC cycles go to IDLE, gnt=0.
- Latency from req seen in IDLE to pipo_enb: 1 cycle. Transaction period: 2+HOLD_CYC cycles, so back-to-back owners are spaced 2+HOLD_CYC cycles apart.
- Data is latched at grant. Changes to req_data or deassertion of req after grant do not affect the transaction; it completes with ack.
- Requester rules:
  - A requester must hold req until it sees ack; it may then drop req.
  - A req still high in the IDLE cycle after HOLD is a new request.
- Fairness: a continuously requesting set is served in cyclic index order. No requester waits more than N_REQ-1 transactions.
- Invariants:
  - gnt is one-hot or zero.
  - ack ⊆ gnt.
  - pipo_enb == |ack.
  - busy == |gnt.
- owner retains its last value in IDLE.
- Width rules: req_data slicing uses owner*DW. N_REQ that is not a power of two wraps explicitly, never via truncation.

Decomposition:
- Package pipo_ctrl_pkg: state enum (IDLE, LOAD, HOLD) and the function onehot(idx).
- Sub-module rr_pick: combinational round-robin priority selector. Inputs req and ptr; outputs valid and idx. Reusable by other arbiters.
- The top holds the FSM, counter, data latch, and pointer. The pipo itself is instantiated by the integrator, not inside this block.

Test Plan (N_REQ=4, DW=4, HOLD_CYC=2, pipo connected):
1. Reset: rst=1 for 2 edges, req=4'hF -> gnt=0, ack=0, pipo_enb=0, pipo_data=0, busy=0, owner=0. The first grant after release goes to 0.
2. Single request: req=4'b0100 with slice2=4'hA at cycle t.
   - t+1: gnt=0100, ack=0100, pipo_enb=1, pipo_data=A.
   - t+2, t+3: gnt=0100, enb=0.
   - t+4: gnt=0, busy=0, pipo o_data=A.
3. All requesting: req=4'hF held, slices 1,2,3,4 -> grants 0,1,2,3,0 spaced exactly 4 cycles apart; pipo o_data sequence 1,2,3,4.
4. Pointer wrap: last owner=1, then req=4'b1010 -> owner 3 wins. Next, req=4'b1010 -> owner 1 wins.
5. Reset during HOLD of owner 2: state IDLE next cycle, gnt=0. With req=4'b1001, owner 0 wins, not 3.
6. Data latch: after grant, change slice to 4'h5 and drop req -> ack still pulses, pipo_enb=1 with the original value 4'hC; no second grant.

Source files
------------

// File: rtl/pipo_ctrl_pkg.sv
// rtl/pipo_ctrl_pkg.sv - shared types and helpers for the pipo round-robin controller
package pipo_ctrl_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // One-hot vector with bit idx set; callers cast down to their own width.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        onehot = MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
module rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N never aliases.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand[PW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/pipo_rr_ctrl.sv
// rtl/pipo_rr_ctrl.sv - round-robin owner of a shared pipo register's load port
module pipo_rr_ctrl
    import pipo_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DW       = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic                     pipo_enb,
    output logic [DW-1:0]            pipo_data,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC);

    state_e          state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic            enb_q;
    logic [DW-1:0]   data_q;
    logic [PW-1:0]   owner_q;
    logic            busy_q;
    logic [7:0]      cnt_q;
    logic [PW-1:0]   ptr_q;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   ptr_d;
    logic [N_REQ-1:0] gnt_d;
    logic [DW-1:0]   data_d;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign gnt_d  = N_REQ'(onehot(int'(pick_idx)));
    assign data_d = req_data[pick_idx*DW +: DW];
    assign ptr_d  = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Grant/load/hold sequencer; every output is a register so the pipo sees clean strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            enb_q   <= 1'b0;
            data_q  <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_LOAD;
                        owner_q <= pick_idx;
                        gnt_q   <= gnt_d;
                        ack_q   <= gnt_d;
                        enb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        data_q  <= data_d;
                        ptr_q   <= ptr_d;
                    end
                end
                ST_LOAD: begin
                    ack_q <= '0;
                    enb_q <= 1'b0;
                    if (HOLD_CYC > 0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= 8'd1;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    enb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign pipo_enb  = enb_q;
    assign pipo_data = data_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pipo_rr_ctrl.sv
// tb/tb_pipo_rr_ctrl.sv - self-checking bench for pipo_rr_ctrl
module tb_pipo_rr_ctrl;

    localparam int N = 4;
    localparam int W = 4;
    localparam int H = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          pipo_enb;
    logic [W-1:0]  pipo_data;
    logic [1:0]    owner;
    logic          busy;
    logic [W-1:0]  pipo_o = '0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: cycles left in the current transaction, owner, pointer, data.
    int           left    = 0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    logic [W-1:0] m_data  = '0;
    logic [W-1:0] m_pipo  = '0;

    pipo_rr_ctrl #(.N_REQ(N), .DW(W), .HOLD_CYC(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .ack       (ack),
        .pipo_enb  (pipo_enb),
        .pipo_data (pipo_data),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // The shared pipo register driven by the controller.
    always @(posedge clk) begin
        if (pipo_enb) pipo_o <= pipo_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit found;
        int c;
        int win;
        if (left == H + 1) m_pipo = m_data;
        if (rst) begin
            left = 0; m_owner = 0; m_ptr = 0; m_data = '0;
        end else if (left > 0) begin
            left--;
        end else if (req != '0) begin
            found = 0;
            win = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req[c]) begin
                    found = 1;
                    win = c;
                end
            end
            m_owner = win;
            m_data  = req_data[win*W +: W];
            m_ptr   = (win + 1) % N;
            left    = H + 1;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] egnt;
        logic [N-1:0] eack;
        egnt = (left > 0) ? N'(1 << m_owner) : '0;
        eack = (left == H + 1) ? egnt : '0;
        check("gnt",       32'(gnt),       32'(egnt));
        check("ack",       32'(ack),       32'(eack));
        check("pipo_enb",  32'(pipo_enb),  32'(eack != '0));
        check("pipo_data", 32'(pipo_data), 32'(m_data));
        check("owner",     32'(owner),     32'(m_owner));
        check("busy",      32'(busy),      32'(left > 0));
        check("pipo_o",    32'(pipo_o),    32'(m_pipo));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // 1. reset with all requesting
        rst = 1'b1; req = 4'hF; req_data = 16'h4321;
        step(); step();
        check("rst_gnt",  32'(gnt),       32'h0);
        check("rst_ack",  32'(ack),       32'h0);
        check("rst_enb",  32'(pipo_enb),  32'h0);
        check("rst_data", 32'(pipo_data), 32'h0);
        check("rst_busy", 32'(busy),      32'h0);
        check("rst_own",  32'(owner),     32'h0);
        rst = 1'b0;
        step();
        check("first_gnt", 32'(gnt), 32'h1);
        req = 4'h0;
        idle_steps(3);

        // 2. single request from requester 2
        req = 4'b0100; req_data = 16'h0A00;
        step();
        check("single_gnt",  32'(gnt),       32'h4);
        check("single_ack",  32'(ack),       32'h4);
        check("single_enb",  32'(pipo_enb),  32'h1);
        check("single_data", 32'(pipo_data), 32'hA);
        req = 4'h0;
        step();
        check("single_hold1", 32'(gnt), 32'h4);
        step();
        check("single_hold2", 32'(gnt), 32'h4);
        check("single_enb2",  32'(pipo_enb), 32'h0);
        step();
        check("single_end_gnt",  32'(gnt),    32'h0);
        check("single_end_busy", 32'(busy),   32'h0);
        check("single_pipo",     32'(pipo_o), 32'hA);

        // 3. all requesting from a fresh pointer: cyclic order, 4-cycle spacing
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'hF; req_data = 16'h4321;
        for (int t = 0; t < 5; t++) begin
            step();
            check("rr_ack",   32'(ack),   32'(1 << (t % 4)));
            check("rr_owner", 32'(owner), 32'(t % 4));
            step();
            check("rr_pipo",  32'(pipo_o), 32'(t % 4 + 1));
            step();
            if (t == 4) req = 4'h0;
            step();
            check("rr_gap", 32'(gnt), 32'h0);
        end

        // 4. pointer wrap
        req = 4'b0010; step(); check("wrap_pre", 32'(owner), 32'h1);
        req = 4'h0; idle_steps(3);
        req = 4'b1010; step(); check("wrap_3", 32'(owner), 32'h3);
        req = 4'h0; idle_steps(3);
        req = 4'b1010; step(); check("wrap_1", 32'(owner), 32'h1);
        req = 4'h0; idle_steps(3);

        // 5. reset during HOLD of owner 2
        req = 4'b0100; step(); check("rh_own", 32'(owner), 32'h2);
        req = 4'h0; step();
        rst = 1'b1; step();
        check("rh_gnt",  32'(gnt),  32'h0);
        check("rh_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        req = 4'b1001; step(); check("rh_win0", 32'(owner), 32'h0);
        req = 4'h0; idle_steps(3);

        // 6. data latched at grant, inputs changed afterwards
        req = 4'b0010; req_data = 16'h00C0;
        step();
        req = 4'h0; req_data = 16'h0050;
        check("latch_ack",  32'(ack),       32'h2);
        check("latch_data", 32'(pipo_data), 32'hC);
        step();
        check("latch_pipo", 32'(pipo_o), 32'hC);
        idle_steps(2);
        step();
        check("latch_nogrant", 32'(gnt), 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            req      = N'($urandom);
            req_data = 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
